// File: rtl/spi_slave_if.sv
// Transmit/receive client bundle of the SPI responder.
// Signal names are seen from the responder side.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_rx_valid;

    modport slave (
        input  i_tx_data,
        input  i_tx_valid,
        output o_tx_ready,
        output o_rx_data,
        output o_rx_valid
    );

    modport master (
        output i_tx_data,
        output i_tx_valid,
        input  o_tx_ready,
        input  o_rx_data,
        input  o_rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// Oversampling SPI responder, all four CPOL/CPHA modes.
// SPI_SLAVE_UNDERRUN_DET_EN enables the sticky TX underrun flag.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic      i_clk,
    input  logic      i_rstn,
    input  logic      i_spi_clk,
    input  logic      i_spi_cs_n,
    input  logic      i_spi_mosi_bit,
    output logic      o_spi_miso_bit,
    output logic      o_spi_miso_oe,
    input  logic      i_cpol,
    input  logic      i_cpha,
    spi_slave_if.slave bus,
    output logic      o_tx_underrun,
    input  logic      i_underrun_clr
);
    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    state_t                 r_state;
    logic [CW-1:0]          r_bit_cnt;
    logic [DATA_WIDTH-2:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic                   r_hold_full;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_oe;

    logic                   w_sclk;
    logic                   w_cs_n;
    logic                   w_mosi;
    logic                   w_edge;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_entry;
    logic                   w_live;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_accept;
    logic                   w_underrun_evt;
    logic [DATA_WIDTH-1:0]  w_load_val;
    logic [DATA_WIDTH-1:0]  w_rx_next;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi_bit};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs_n;
        end
    end

    assign w_sclk  = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n  = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle level, trailing edge returns to it
    assign w_edge  = w_sclk ^ r_sclk_prev;
    assign w_lead  = w_edge & (r_sclk_prev == i_cpol);
    assign w_trail = w_edge & (w_sclk == i_cpol);

    assign w_entry  = (r_state == S_IDLE) & r_cs_prev & ~w_cs_n;
    assign w_live   = (r_state == S_ACTIVE) & ~w_cs_n;
    assign w_sample = w_live & (i_cpha ? w_trail : w_lead);
    assign w_shift  = w_live & (i_cpha ? w_lead : w_trail);

    assign w_load = (w_entry & ~i_cpha)
                  | (w_shift & (r_bit_cnt == '0));
    assign w_accept       = bus.i_tx_valid & ~r_hold_full;
    assign w_underrun_evt = w_load & ~r_hold_full;
    assign w_load_val     = r_hold_full ? r_hold : '1;
    assign w_rx_next      = {r_rx_shift, w_mosi};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '1;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;

            // An empty-register load and an accept in one cycle keep the new byte
            if (w_load & r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold      <= bus.i_tx_data;
            end

            unique case (r_state)
                S_IDLE: begin
                    r_oe      <= 1'b0;
                    r_bit_cnt <= '0;
                    if (w_entry) begin
                        r_state    <= S_ACTIVE;
                        r_oe       <= 1'b1;
                        r_tx_shift <= i_cpha ? '1 : w_load_val;
                    end
                end
                S_ACTIVE: begin
                    if (w_cs_n) begin
                        r_state    <= S_IDLE;
                        r_oe       <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        r_tx_shift <= '1;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
                            if (r_bit_cnt == LAST) begin
                                r_bit_cnt  <= '0;
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        if (w_shift) begin
                            r_tx_shift <= (r_bit_cnt == '0) ? w_load_val
                                        : {r_tx_shift[DATA_WIDTH-2:0], 1'b1};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_DET_EN
    logic r_underrun;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_evt) begin
            r_underrun <= 1'b1;
        end else if (i_underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign o_tx_underrun = r_underrun;
`else
    logic w_unused;

    assign w_unused      = i_underrun_clr | w_underrun_evt;
    assign o_tx_underrun = 1'b0;
`endif

    assign o_spi_miso_bit = r_tx_shift[DATA_WIDTH-1];
    assign o_spi_miso_oe  = r_oe;
    assign bus.o_tx_ready = ~r_hold_full;
    assign bus.o_rx_data  = r_rx_data;
    assign bus.o_rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed vector table, reset abort and
// random frames against a byte-level SPI master model.
`timescale 1ns/1ps
module tb_spi_slave;
    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int HALF  = 8;
    localparam int SETUP = 10;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic cpol  = 1'b0;
    logic cpha  = 1'b0;
    logic clr   = 1'b0;
    logic miso;
    logic oe;
    logic und;

    int checks   = 0;
    int failures = 0;
    bit und_model = 1'b0;
    logic [7:0] rx_got[$];

    spi_slave_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_spi_clk      (sclk),
        .i_spi_cs_n     (cs_n),
        .i_spi_mosi_bit (mosi),
        .o_spi_miso_bit (miso),
        .o_spi_miso_oe  (oe),
        .i_cpol         (cpol),
        .i_cpha         (cpha),
        .bus            (bus),
        .o_tx_underrun  (und),
        .i_underrun_clr (clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rstn && bus.o_rx_valid) rx_got.push_back(bus.o_rx_data);

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.o_tx_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_tx_ready) begin
            checks++;
            failures++;
            $display("FAIL tx_ready_timeout actual=0 required=1");
        end else begin
            bus.i_tx_valid = 1'b1;
            bus.i_tx_data  = d;
            @(posedge clk);
            #1;
            bus.i_tx_valid = 1'b0;
        end
    endtask

    task automatic clear_und();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        und_model = 1'b0;
    endtask

    // SPI master: drives MOSI one half-period ahead of each sample edge
    task automatic frame(input bit pol, input bit pha, input int nbits,
                         input logic [15:0] mo, output logic [15:0] mi);
        mi = '0;
        cpol = pol;
        cpha = pha;
        sclk = pol;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        if (!pha) mosi = mo[nbits-1];
        repeat (SETUP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (pha) mosi = mo[nbits-1-i];
            if (i == 0) check("oe_active", oe, 1);
            sclk = ~pol;
            if (!pha) mi = {mi[14:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = pol;
            if (pha) mi = {mi[14:0], miso};
            else if (i < nbits - 1) mosi = mo[nbits-2-i];
            repeat (HALF) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    function automatic int n_loads(bit pha, int nbits);
        return pha ? (nbits + 7) / 8 : 1 + nbits / 8;
    endfunction

    // Bytes leave in push order; any load with nothing queued sends all-ones
    function automatic logic [15:0] model_miso(int nbits, int ntx,
                                               logic [15:0] tx);
        logic [23:0] s;
        s = {(ntx > 0) ? tx[15:8] : 8'hFF,
             (ntx > 1) ? tx[7:0]  : 8'hFF,
             8'hFF};
        return 16'(s >> (24 - nbits));
    endfunction

    task automatic run_frame(input bit pol, input bit pha, input int nbits,
                             input logic [15:0] mo, input int ntx,
                             input logic [15:0] tx, output logic [15:0] mi);
        logic [15:0] m;
        rx_got.delete();
        if (ntx > 0) push_tx(tx[15:8]);
        fork
            frame(pol, pha, nbits, mo, m);
            begin
                if (ntx > 1) push_tx(tx[7:0]);
            end
        join
        mi = m;
`ifdef SPI_SLAVE_UNDERRUN_DET_EN
        if (n_loads(pha, nbits) > ntx) und_model = 1'b1;
`endif
    endtask

    task automatic check_frame(input string tag, input logic [15:0] mi,
                               input logic [15:0] emi, input int nrx,
                               input logic [7:0] e0, input logic [7:0] e1);
        check({tag, "_miso"}, mi, emi);
        check({tag, "_rxcnt"}, rx_got.size(), nrx);
        for (int k = 0; k < nrx && k < rx_got.size(); k++)
            check({tag, "_rx"}, rx_got[k], (k == 0) ? e0 : e1);
        check({tag, "_underrun"}, und, und_model);
        check({tag, "_ready"}, bus.o_tx_ready, 1);
        check({tag, "_oe_idle"}, oe, 0);
    endtask

    typedef struct {
        bit          pol;
        bit          pha;
        int          nbits;
        logic [15:0] mo;
        int          ntx;
        logic [15:0] tx;
        logic [15:0] emi;
        int          nrx;
        logic [15:0] erx;
    } vec_t;

    initial begin
        vec_t        vt[7];
        logic [15:0] mi;
        logic [15:0] mo;
        logic [15:0] tx;
        logic [7:0]  e0;
        logic [7:0]  e1;
        bit          pol;
        bit          pha;
        int          nbits;
        int          ntx;
        int          lds;

        vt[0] = '{0, 0,  8, 16'h00A5, 1, 16'h3C00, 16'h003C, 1, 16'hA500};
        vt[1] = '{1, 1,  8, 16'h007E, 1, 16'h8100, 16'h0081, 1, 16'h7E00};
        vt[2] = '{0, 1, 16, 16'hC35A, 2, 16'h1122, 16'h1122, 2, 16'hC35A};
        vt[3] = '{0, 0,  8, 16'h005B, 0, 16'h0000, 16'h00FF, 1, 16'h5B00};
        vt[4] = '{0, 0,  5, 16'h0016, 0, 16'h0000, 16'h001F, 0, 16'h0000};
        vt[5] = '{0, 0,  8, 16'h0096, 0, 16'h0000, 16'h00FF, 1, 16'h9600};
        vt[6] = '{1, 0,  8, 16'h004D, 1, 16'hE700, 16'h00E7, 1, 16'h4D00};

        bus.i_tx_valid = 1'b0;
        bus.i_tx_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_miso", miso, 1);
        check("rst_oe", oe, 0);
        check("rst_ready", bus.o_tx_ready, 1);
        check("rst_rx_data", bus.o_rx_data, 0);
        check("rst_rx_valid", bus.o_rx_valid, 0);
        check("rst_underrun", und, 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            clear_und();
            run_frame(vt[i].pol, vt[i].pha, vt[i].nbits, vt[i].mo,
                      vt[i].ntx, vt[i].tx, mi);
            check_frame($sformatf("vec%0d", i), mi, vt[i].emi, vt[i].nrx,
                        vt[i].erx[15:8], vt[i].erx[7:0]);
            clear_und();
            check($sformatf("vec%0d_und_clr", i), und, 0);
        end

        // Reset pulse in the middle of a mode-0 frame
        push_tx(8'h5A);
        rx_got.delete();
        fork
            frame(0, 0, 8, 16'h00F0, mi);
            begin
                repeat (18) @(negedge clk);
                push_tx(8'h77);
                repeat (30) @(negedge clk);
                check("rst_pre_ready", bus.o_tx_ready, 0);
                check("rst_pre_oe", oe, 1);
                rstn = 1'b0;
                #1;
                check("rstmid_miso", miso, 1);
                check("rstmid_oe", oe, 0);
                check("rstmid_ready", bus.o_tx_ready, 1);
                check("rstmid_rx_data", bus.o_rx_data, 0);
                check("rstmid_rx_valid", bus.o_rx_valid, 0);
                check("rstmid_underrun", und, 0);
                @(negedge clk);
                rstn = 1'b1;
            end
        join
        check("rstmid_no_rx", rx_got.size(), 0);
        clear_und();
        run_frame(0, 0, 8, 16'h00C7, 1, 16'h3900, mi);
        check_frame("post_rst", mi, 16'h0039, 1, 8'hC7, 8'h00);

        // Random frames, modes, lengths and TX supply
        for (int r = 0; r < 30; r++) begin
            pol   = 1'($urandom_range(0, 1));
            pha   = 1'($urandom_range(0, 1));
            nbits = $urandom_range(1, 16);
            mo    = 16'($urandom) & 16'((32'd1 << nbits) - 1);
            lds   = n_loads(pha, nbits);
            ntx   = $urandom_range(0, (lds < 2) ? lds : 2);
            tx    = 16'($urandom);
            if ($urandom_range(0, 1) == 1) clear_und();
            run_frame(pol, pha, nbits, mo, ntx, tx, mi);
            e0 = (nbits >= 8)  ? 8'(mo >> (nbits - 8)) : 8'h00;
            e1 = (nbits >= 16) ? mo[7:0] : 8'h00;
            check_frame($sformatf("rnd%0d", r), mi,
                        model_miso(nbits, ntx, tx), nbits / 8, e0, e1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
